mppt_po_datapath: RTL and testbench
===================================

Name: mppt_po_datapath

Overview:
- Perturb-and-observe datapath for the open-loop MPPT controller.
- Sits directly downstream of the controller's state decoder and consumes its one-hot enable vector en[3:0].
- Latches the ADC voltage and current samples, computes panel power, and compares it with the power from the previous iteration.
- Steps a saturating PWM duty register in the direction that raised power; the duty value feeds the PWM stage.

Parameters:
- DW, 12: ADC sample width (voltage and current).
- DUTY_W, 10: width of the duty register.
- DUTY_INIT, 512: duty value after reset.
- DUTY_MIN, 64: lower duty clamp (inclusive).
- DUTY_MAX, 960: upper duty clamp (inclusive).
- STEP, 8: duty perturbation per update.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  4  one-hot phase enables from the decoder:
  - [0] latch voltage
  - [1] latch current
  - [2] compute power
  - [3] update duty
- v_adc  in  DW  voltage sample, unsigned.
- i_adc  in  DW  current sample, unsigned.
- duty  out  DUTY_W  current duty command.
- dir  out  1  perturbation direction (1 = increase duty).
- p_cur  out  2*DW  most recently computed power.
- upd_done  out  1  single-cycle pulse the cycle after an en[3] update.
- sat  out  1  single-cycle pulse when an update hit DUTY_MIN or DUTY_MAX.

Behaviour:
- Reset values (rst=1 at an edge):
  - duty=DUTY_INIT, dir=1.
  - p_cur=0, p_prev=0.
  - v_reg=0, i_reg=0.
  - first=1 (internal).
  - upd_done=0, sat=0.
  - rst overrides any en activity in the same cycle.
- en[0]: v_reg <= v_adc.
- en[1]: i_reg <= i_adc.
- en[2]: p_cur <= v_reg * i_reg.
  - Unsigned, full 2*DW width, no truncation.
  - Registered; latency 1 cycle from en[2].
- en[3], comparison and direction:
  - If first=1: no comparison, dir unchanged, first <= 0.
  - Else if p_cur < p_prev: dir <= ~dir.
  - Else (p_cur >= p_prev, including equal): dir unchanged.
- en[3], duty step (uses the post-comparison direction d):
  - d=1: if duty + STEP > DUTY_MAX, then duty <= DUTY_MAX, dir <= 0, sat pulses. Otherwise duty <= duty + STEP.
  - d=0: if duty < DUTY_MIN + STEP, then duty <= DUTY_MIN, dir <= 1, sat pulses. Otherwise duty <= duty - STEP.
  - Compute duty arithmetic at DUTY_W+1 bits so neither overflow nor underflow wraps.
  - p_prev <= p_cur.
  - upd_done <= 1 on the next cycle; 0 otherwise.
- Simultaneous enables (not produced by the decoder, but defined):
  - Each enabled action executes in the same cycle using pre-edge register values.
  - Example: en[2] together with en[0] multiplies the old v_reg.
  - Example: en[2] together with en[3] compares the old p_cur.
- en=0: all registers hold; pulses deassert.
- Reset mid-iteration (e.g. after en[2], before en[3]):
  - Everything returns to reset values, including first=1.
  - The next en[3] after reset performs an uncompared step.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package mppt_pkg:
  - Enable index constants EN_V=0, EN_I=1, EN_P=2, EN_D=3.
  - Default width constants DW and DUTY_W.
  - The same constants are used by the decoder-side logic.
- One sub-module, mppt_duty_stepper:
  - Inputs: duty, dir, STEP, clamp limits.
  - Outputs: next duty, next dir, saturation flag.
  - Combinational; the top level registers its outputs.

Test Plan:
1. Reset -> duty=512, dir=1, p_cur=0, upd_done=0, sat=0.
2. First iteration: v_adc=1000 with en[0]; i_adc=200 with en[1]; then en[2]; then en[3] -> p_cur=200000, duty=520, dir=1, upd_done high exactly one cycle.
3. Second iteration with v=1000, i=210 -> p_cur=210000, duty=528, dir=1. Third iteration with i=150 -> p_cur=150000 < 210000, so dir=0 and duty=520.
4. Equal power: repeat an iteration with identical v and i -> dir unchanged, duty moves by 8 in the same direction.
5. Upper saturation: from reset, apply increasing-power iterations -> duty reaches 960 after 56 updates. The 57th update -> duty=960, dir=0, sat pulses one cycle. Mirror test at DUTY_MIN=64 -> dir=1.
6. Reset asserted one cycle after en[2] -> all outputs return to reset values. The following full iteration with p=100000 steps duty to 520 with no direction flip (first-update rule).

Source files
------------

// File: rtl/mppt_pkg.sv
// Shared constants for the MPPT controller: phase-enable bit positions and default widths.
// Used by both the state decoder and the perturb-and-observe datapath.
package mppt_pkg;

    localparam int EN_W   = 4;
    localparam int EN_V   = 0;
    localparam int EN_I   = 1;
    localparam int EN_P   = 2;
    localparam int EN_D   = 3;

    localparam int DW     = 12;
    localparam int DUTY_W = 10;

endpackage

// File: rtl/mppt_duty_stepper.sv
// Combinational saturating duty stepper: moves duty by one step in direction dir,
// clamping at the inclusive limits and flipping direction when a clamp is hit.
module mppt_duty_stepper #(
    parameter int W = 10
) (
    input  logic [W-1:0] duty,
    input  logic         dir,
    input  logic [W-1:0] step,
    input  logic [W-1:0] duty_min,
    input  logic [W-1:0] duty_max,
    output logic [W-1:0] duty_next,
    output logic         dir_next,
    output logic         sat
);

    logic [W:0] up_s;
    logic [W:0] lo_s;

    // One extra bit keeps both the sum and the lower threshold from wrapping
    assign up_s = {1'b0, duty} + {1'b0, step};
    assign lo_s = {1'b0, duty_min} + {1'b0, step};

    // Next duty, direction and saturation flag
    always_comb begin
        duty_next = duty;
        dir_next  = dir;
        sat       = 1'b0;
        if (dir) begin
            if (up_s > {1'b0, duty_max}) begin
                duty_next = duty_max;
                dir_next  = 1'b0;
                sat       = 1'b1;
            end else begin
                duty_next = up_s[W-1:0];
                dir_next  = 1'b1;
                sat       = 1'b0;
            end
        end else begin
            if ({1'b0, duty} < lo_s) begin
                duty_next = duty_min;
                dir_next  = 1'b1;
                sat       = 1'b1;
            end else begin
                duty_next = duty - step;
                dir_next  = 1'b0;
                sat       = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mppt_po_datapath.sv
// Perturb-and-observe MPPT datapath: latches V/I samples, computes power, and steps a
// saturating duty register toward the direction that last raised power.
module mppt_po_datapath
    import mppt_pkg::*;
#(
    parameter int DW        = mppt_pkg::DW,
    parameter int DUTY_W    = mppt_pkg::DUTY_W,
    parameter int DUTY_INIT = 512,
    parameter int DUTY_MIN  = 64,
    parameter int DUTY_MAX  = 960,
    parameter int STEP      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [EN_W-1:0]     en,
    input  logic [DW-1:0]       v_adc,
    input  logic [DW-1:0]       i_adc,
    output logic [DUTY_W-1:0]   duty,
    output logic                dir,
    output logic [2*DW-1:0]     p_cur,
    output logic                upd_done,
    output logic                sat
);

    logic [DW-1:0]     v_reg_r;
    logic [DW-1:0]     i_reg_r;
    logic [2*DW-1:0]   p_cur_r;
    logic [2*DW-1:0]   p_prev_r;
    logic [DUTY_W-1:0] duty_r;
    logic              dir_r;
    logic              first_r;
    logic              upd_done_r;
    logic              sat_r;

    logic [2*DW-1:0]   prod_s;
    logic              dir_cmp_s;
    logic [DUTY_W-1:0] duty_next_s;
    logic              dir_next_s;
    logic              sat_s;

    assign prod_s = (2*DW)'(v_reg_r) * (2*DW)'(i_reg_r);

    // Direction after the power comparison; the first update after reset has nothing to compare
    always_comb begin
        dir_cmp_s = dir_r;
        if (first_r) begin
            dir_cmp_s = dir_r;
        end else if (p_cur_r < p_prev_r) begin
            dir_cmp_s = ~dir_r;
        end else begin
            dir_cmp_s = dir_r;
        end
    end

    mppt_duty_stepper #(
        .W(DUTY_W)
    ) u_stepper (
        .duty      (duty_r),
        .dir       (dir_cmp_s),
        .step      (DUTY_W'(STEP)),
        .duty_min  (DUTY_W'(DUTY_MIN)),
        .duty_max  (DUTY_W'(DUTY_MAX)),
        .duty_next (duty_next_s),
        .dir_next  (dir_next_s),
        .sat       (sat_s)
    );

    // Phase-enabled state updates; simultaneous enables all see pre-edge values
    always_ff @(posedge clk) begin
        if (rst) begin
            v_reg_r    <= '0;
            i_reg_r    <= '0;
            p_cur_r    <= '0;
            p_prev_r   <= '0;
            duty_r     <= DUTY_W'(DUTY_INIT);
            dir_r      <= 1'b1;
            first_r    <= 1'b1;
            upd_done_r <= 1'b0;
            sat_r      <= 1'b0;
        end else begin
            if (en[EN_V]) begin
                v_reg_r <= v_adc;
            end
            if (en[EN_I]) begin
                i_reg_r <= i_adc;
            end
            if (en[EN_P]) begin
                p_cur_r <= prod_s;
            end
            if (en[EN_D]) begin
                duty_r     <= duty_next_s;
                dir_r      <= dir_next_s;
                sat_r      <= sat_s;
                p_prev_r   <= p_cur_r;
                first_r    <= 1'b0;
                upd_done_r <= 1'b1;
            end else begin
                sat_r      <= 1'b0;
                upd_done_r <= 1'b0;
            end
        end
    end

    assign duty     = duty_r;
    assign dir      = dir_r;
    assign p_cur    = p_cur_r;
    assign upd_done = upd_done_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_mppt_po_datapath.sv
// Directed self-checking bench for mppt_po_datapath with hand-computed expectations.
module tb_mppt_po_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic [11:0] v_adc;
    logic [11:0] i_adc;
    logic [9:0]  duty;
    logic        dir;
    logic [23:0] p_cur;
    logic        upd_done;
    logic        sat;

    int n_vec = 0;
    int n_err = 0;

    mppt_po_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .v_adc    (v_adc),
        .i_adc    (i_adc),
        .duty     (duty),
        .dir      (dir),
        .p_cur    (p_cur),
        .upd_done (upd_done),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; effects are visible at the next falling edge
    task automatic drive(input logic r, input logic [3:0] e, input logic [11:0] v, input logic [11:0] i);
        @(negedge clk);
        rst   = r;
        en    = e;
        v_adc = v;
        i_adc = i;
    endtask

    // Full iteration; returns with en idle and the en[3] edge's results observable
    task automatic iterate(input logic [11:0] v, input logic [11:0] i);
        drive(1'b0, 4'b0001, v, 12'd0);
        drive(1'b0, 4'b0010, 12'd0, i);
        drive(1'b0, 4'b0100, 12'd0, 12'd0);
        drive(1'b0, 4'b1000, 12'd0, 12'd0);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 12'd0, 12'd0);
        drive(1'b1, 4'b1111, 12'd7, 12'd7);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
    endtask

    initial begin
        rst = 1'b1; en = 4'b0000; v_adc = 12'd0; i_adc = 12'd0;

        // 1. reset state (rst also held against en activity)
        do_reset();
        check_eq("rst_duty", 32'(duty), 32'd512);
        check_eq("rst_dir", 32'(dir), 32'd1);
        check_eq("rst_p", 32'(p_cur), 32'd0);
        check_eq("rst_upd", 32'(upd_done), 32'd0);
        check_eq("rst_sat", 32'(sat), 32'd0);

        // 2. first iteration
        iterate(12'd1000, 12'd200);
        check_eq("it1_p", 32'(p_cur), 32'd200000);
        check_eq("it1_duty", 32'(duty), 32'd520);
        check_eq("it1_dir", 32'(dir), 32'd1);
        check_eq("it1_upd", 32'(upd_done), 32'd1);
        check_eq("it1_sat", 32'(sat), 32'd0);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
        check_eq("it1_upd_off", 32'(upd_done), 32'd0);
        check_eq("hold_duty", 32'(duty), 32'd520);

        // 3. rising then falling power
        iterate(12'd1000, 12'd210);
        check_eq("it2_p", 32'(p_cur), 32'd210000);
        check_eq("it2_duty", 32'(duty), 32'd528);
        check_eq("it2_dir", 32'(dir), 32'd1);
        iterate(12'd1000, 12'd150);
        check_eq("it3_p", 32'(p_cur), 32'd150000);
        check_eq("it3_dir", 32'(dir), 32'd0);
        check_eq("it3_duty", 32'(duty), 32'd520);

        // 4. equal power keeps direction
        iterate(12'd1000, 12'd150);
        check_eq("eq_dir", 32'(dir), 32'd0);
        check_eq("eq_duty", 32'(duty), 32'd512);

        // simultaneous en[0]+en[2] multiplies the old voltage
        drive(1'b0, 4'b0101, 12'd2000, 12'd0);
        drive(1'b0, 4'b0100, 12'd0, 12'd0);
        check_eq("simul_old_v", 32'(p_cur), 32'd150000);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
        check_eq("simul_new_v", 32'(p_cur), 32'd300000);

        // 5. upper saturation after 56 rising-power updates
        do_reset();
        for (int k = 0; k < 56; k++) iterate(12'd1000, 12'(100 + k));
        check_eq("up56_duty", 32'(duty), 32'd960);
        check_eq("up56_dir", 32'(dir), 32'd1);
        check_eq("up56_sat", 32'(sat), 32'd0);
        iterate(12'd1000, 12'd156);
        check_eq("up57_duty", 32'(duty), 32'd960);
        check_eq("up57_dir", 32'(dir), 32'd0);
        check_eq("up57_sat", 32'(sat), 32'd1);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
        check_eq("up57_sat_off", 32'(sat), 32'd0);

        // mirror: 112 downward steps reach 64, the next one saturates low
        for (int k = 0; k < 112; k++) iterate(12'd1000, 12'(157 + k));
        check_eq("dn112_duty", 32'(duty), 32'd64);
        check_eq("dn112_dir", 32'(dir), 32'd0);
        check_eq("dn112_sat", 32'(sat), 32'd0);
        iterate(12'd1000, 12'd269);
        check_eq("dn113_duty", 32'(duty), 32'd64);
        check_eq("dn113_dir", 32'(dir), 32'd1);
        check_eq("dn113_sat", 32'(sat), 32'd1);

        // 6. reset one cycle after en[2]
        drive(1'b0, 4'b0001, 12'd900, 12'd0);
        drive(1'b0, 4'b0010, 12'd0, 12'd300);
        drive(1'b0, 4'b0100, 12'd0, 12'd0);
        drive(1'b1, 4'b0000, 12'd0, 12'd0);
        drive(1'b0, 4'b0000, 12'd0, 12'd0);
        check_eq("mid_rst_duty", 32'(duty), 32'd512);
        check_eq("mid_rst_dir", 32'(dir), 32'd1);
        check_eq("mid_rst_p", 32'(p_cur), 32'd0);
        check_eq("mid_rst_upd", 32'(upd_done), 32'd0);
        iterate(12'd500, 12'd200);
        check_eq("post_rst_p", 32'(p_cur), 32'd100000);
        check_eq("post_rst_duty", 32'(duty), 32'd520);
        check_eq("post_rst_dir", 32'(dir), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
